disp_scan_mux: RTL and testbench

- Time-multiplexes a 16-bit hex value across the 4-digit common-anode seven-segment display.
- Sits directly upstream of the hex-to-seven-segment decoder. Takes the second counter value and drives one digit select plus one 4-bit nibble at a time.
- Inserts a blanking gap between digits to suppress ghosting.
- Snapshots the value once per frame so digits never tear mid-frame.

---
 rtl/disp_scan_mux.sv | 69 ++++++
 tb/tb_disp_scan_mux.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_mux.sv
// disp_scan_mux: 4-digit seven-segment scan multiplexer with blanking gaps and per-frame snapshot.
// Optional leading-zero blanking is enabled by defining DISP_SCAN_MUX_LZB_EN.
module disp_scan_mux #(
    parameter int REFRESH_CYCLES = 12000,
    parameter int BLANK_CYCLES   = 600
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] VALUE,
    input  logic        HOLD,
    output logic [3:0]  HEX,
    output logic        BLANK,
    output logic [3:0]  COMM,
    output logic        FRAME_DONE
);
    typedef enum logic {GAP, DRIVE} state_t;
    localparam logic [23:0] REF_LD = 24'(REFRESH_CYCLES - 1);
    localparam logic [23:0] BLK_LD = 24'(BLANK_CYCLES - 1);
    state_t      r_state;
    logic [1:0]  r_digit;
    logic [23:0] r_timer;
    logic [15:0] r_snap;
    logic        w_capture;
    logic [15:0] w_snap;
    logic [3:0]  w_hex;
    logic        w_lzb;
    // Digit 0 must show the value captured on the same edge it starts driving.
    assign w_capture = (r_state == GAP) && (r_timer == '0) && (r_digit == 2'd0) && !HOLD;
    assign w_snap    = w_capture ? VALUE : r_snap;
    assign w_hex     = w_snap[{r_digit, 2'b00} +: 4];
`ifdef DISP_SCAN_MUX_LZB_EN
    logic [15:0] w_hi;
    assign w_hi  = w_snap >> {r_digit, 2'b00};
    assign w_lzb = (r_digit != 2'd0) && (w_hi == 16'h0);
`else
    assign w_lzb = 1'b0;
`endif
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= GAP;
            r_digit    <= 2'd0;
            r_timer    <= BLK_LD;
            r_snap     <= 16'h0000;
            HEX        <= 4'h0;
            BLANK      <= 1'b1;
            COMM       <= 4'b0000;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            if (r_timer != '0) begin
                r_timer <= r_timer - 24'd1;
            end else if (r_state == GAP) begin
                r_state <= DRIVE;
                r_timer <= REF_LD;
                r_snap  <= w_snap;
                COMM    <= 4'b0001 << r_digit;
                HEX     <= w_hex;
                BLANK   <= w_lzb;
            end else begin
                r_state    <= GAP;
                r_timer    <= BLK_LD;
                r_digit    <= r_digit + 2'd1;
                COMM       <= 4'b0000;
                BLANK      <= 1'b1;
                FRAME_DONE <= (r_digit == 2'd3);
            end
        end
    end
endmodule

// File: tb/tb_disp_scan_mux.sv
// tb_disp_scan_mux: directed checks of scan order, snapshot, hold, async reset, one-hot and leading-zero blanking.
module tb_disp_scan_mux;
    logic        CLK = 1'b0;
    logic        rst_n, hold, rst1_n;
    logic [15:0] value, value1;
    logic [3:0]  hex, comm, hex1, comm1;
    logic        blank, fd, blank1, fd1;
    int          k, n_checks, n_fail;

    always #5 CLK = ~CLK;

    disp_scan_mux #(.REFRESH_CYCLES(4), .BLANK_CYCLES(2)) dut (
        .CLK(CLK), .RST_N(rst_n), .VALUE(value), .HOLD(hold),
        .HEX(hex), .BLANK(blank), .COMM(comm), .FRAME_DONE(fd)
    );

    disp_scan_mux #(.REFRESH_CYCLES(1), .BLANK_CYCLES(1)) dut1 (
        .CLK(CLK), .RST_N(rst1_n), .VALUE(value1), .HOLD(1'b0),
        .HEX(hex1), .BLANK(blank1), .COMM(comm1), .FRAME_DONE(fd1)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
        k++;
    endtask

    // Frame of 24 cycles for R=4,B=2: cycles p%6 in {0,1} are gap, else digit p/6 is driven.
    function automatic logic [3:0] exp_comm(int kk);
        int p = kk % 24;
        return (p % 6 >= 2) ? 4'(1 << (p / 6)) : 4'b0000;
    endfunction

    function automatic logic exp_blank(logic [15:0] v, int d);
`ifdef DISP_SCAN_MUX_LZB_EN
        return (d != 0) && ((v >> (4 * d)) == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] nib(logic [15:0] v, int d);
        return 4'(v >> (4 * d));
    endfunction

    task automatic test_reset;
        int p, d;
        rst_n = 1'b0; value = 16'hACD8; hold = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++; if (hex !== 4'h0) begin n_fail++; $display("FAIL reset_hex got %h exp 0", hex); end
        n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL reset_blank got %b exp 1", blank); end
        n_checks++; if (comm !== 4'b0000) begin n_fail++; $display("FAIL reset_comm got %b exp 0000", comm); end
        n_checks++; if (fd !== 1'b0) begin n_fail++; $display("FAIL reset_fd got %b exp 0", fd); end
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 48; i++) begin
            tick;
            p = k % 24; d = p / 6;
            n_checks++; if (comm !== exp_comm(k)) begin n_fail++; $display("FAIL scan_comm k=%0d got %b exp %b", k, comm, exp_comm(k)); end
            n_checks++; if (fd !== (p == 0)) begin n_fail++; $display("FAIL scan_fd k=%0d got %b exp %b", k, fd, p == 0); end
            if (p % 6 >= 2) begin
                n_checks++; if (hex !== nib(16'hACD8, d)) begin n_fail++; $display("FAIL scan_hex k=%0d got %h exp %h", k, hex, nib(16'hACD8, d)); end
                n_checks++; if (blank !== 1'b0) begin n_fail++; $display("FAIL scan_blank k=%0d got %b exp 0", k, blank); end
            end else begin
                n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL gap_blank k=%0d got %b exp 1", k, blank); end
            end
        end
    endtask

    task automatic test_tearing;
        int p, d;
        logic [15:0] e;
        value = 16'h1234;
        for (int i = 0; i < 48; i++) begin
            if (k == 57) value = 16'h5678;
            tick;
            p = k % 24; d = p / 6;
            e = (k < 74) ? 16'h1234 : 16'h5678;
            if (p % 6 >= 2) begin
                n_checks++; if (hex !== nib(e, d)) begin n_fail++; $display("FAIL tear_hex k=%0d got %h exp %h", k, hex, nib(e, d)); end
            end
        end
    endtask

    task automatic test_hold;
        int p, d;
        logic [15:0] e;
        hold = 1'b1; value = 16'hFFFF;
        for (int i = 0; i < 72; i++) begin
            if (k == 144) hold = 1'b0;
            if (k == 150) hold = 1'b1;
            tick;
            p = k % 24; d = p / 6;
            e = (k < 146) ? 16'h5678 : 16'hFFFF;
            if (p % 6 >= 2) begin
                n_checks++; if (hex !== nib(e, d)) begin n_fail++; $display("FAIL hold_hex k=%0d got %h exp %h", k, hex, nib(e, d)); end
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_async_reset;
        int p, d;
        while (k % 24 != 15) tick;
        n_checks++; if (comm !== 4'b0100) begin n_fail++; $display("FAIL pre_reset_comm got %b exp 0100", comm); end
        #2;
        rst_n = 1'b0; hold = 1'b1; value = 16'h1234;
        #1;
        n_checks++; if (comm !== 4'b0000) begin n_fail++; $display("FAIL async_comm got %b exp 0000", comm); end
        n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL async_blank got %b exp 1", blank); end
        n_checks++; if (hex !== 4'h0) begin n_fail++; $display("FAIL async_hex got %h exp 0", hex); end
        n_checks++; if (fd !== 1'b0) begin n_fail++; $display("FAIL async_fd got %b exp 0", fd); end
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 24; i++) begin
            tick;
            p = k % 24; d = p / 6;
            n_checks++; if (comm !== exp_comm(k)) begin n_fail++; $display("FAIL restart_comm k=%0d got %b exp %b", k, comm, exp_comm(k)); end
            if (p % 6 >= 2) begin
                n_checks++; if (hex !== 4'h0) begin n_fail++; $display("FAIL held_zero_hex k=%0d got %h exp 0", k, hex); end
                n_checks++; if (blank !== exp_blank(16'h0000, d)) begin n_fail++; $display("FAIL held_zero_blank k=%0d got %b exp %b", k, blank, exp_blank(16'h0000, d)); end
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_lzb;
        int p, d;
        logic [15:0] e;
        value = 16'h0050;
        for (int i = 0; i < 48; i++) begin
            if (k == 48) value = 16'h0000;
            tick;
            p = k % 24; d = p / 6;
            e = (k < 48) ? 16'h0050 : 16'h0000;
            if (p % 6 >= 2) begin
                n_checks++; if (blank !== exp_blank(e, d)) begin n_fail++; $display("FAIL lzb_blank k=%0d got %b exp %b", k, blank, exp_blank(e, d)); end
                n_checks++; if (comm !== exp_comm(k)) begin n_fail++; $display("FAIL lzb_comm k=%0d got %b exp %b", k, comm, exp_comm(k)); end
                if (!exp_blank(e, d)) begin
                    n_checks++; if (hex !== nib(e, d)) begin n_fail++; $display("FAIL lzb_hex k=%0d got %h exp %h", k, hex, nib(e, d)); end
                end
            end
        end
    endtask

    task automatic test_one_hot;
        int j, p, fdc;
        int cnt[4];
        logic [15:0] v, cap;
        j = 0; fdc = 0; cap = 16'h0;
        for (int d = 0; d < 4; d++) cnt[d] = 0;
        @(posedge CLK);
        #1;
        rst1_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            v = 16'($urandom);
            value1 = v;
            if ((j + 1) % 8 == 1) cap = v;
            @(posedge CLK);
            #1;
            j++;
            p = j % 8;
            n_checks++; if ($countones(comm1) > 1) begin n_fail++; $display("FAIL onehot j=%0d got %b exp at most one bit", j, comm1); end
            if (p % 2 == 1) begin
                n_checks++; if (comm1 !== 4'(1 << (p / 2))) begin n_fail++; $display("FAIL fast_comm j=%0d got %b exp %b", j, comm1, 4'(1 << (p / 2))); end
                n_checks++; if (hex1 !== nib(cap, p / 2)) begin n_fail++; $display("FAIL fast_hex j=%0d got %h exp %h", j, hex1, nib(cap, p / 2)); end
            end else begin
                n_checks++; if (blank1 !== 1'b1) begin n_fail++; $display("FAIL fast_gap_blank j=%0d got %b exp 1", j, blank1); end
            end
            for (int d = 0; d < 4; d++) if (comm1[d]) cnt[d]++;
            if (fd1) fdc++;
        end
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (cnt[d] != 10) begin n_fail++; $display("FAIL drive_count digit %0d got %0d exp 10", d, cnt[d]); end
        end
        n_checks++; if (fdc != 10) begin n_fail++; $display("FAIL frame_done_count got %0d exp 10", fdc); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; k = 0;
        rst1_n = 1'b0; value1 = 16'h0;
        test_reset;
        test_tearing;
        test_hold;
        test_async_reset;
        test_lzb;
        test_one_hot;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
